// File: rtl/dds_phase_gen.sv
// DDS phase generator: converts a 10 Hz-unit frequency setting into a
// frequency tuning word with a sequential shift-add multiplier and drives
// a free-running phase accumulator whose MSBs address the sine ROM.
module dds_phase_gen #(
    parameter int unsigned       ACC_W     = 32,
    parameter int unsigned       STEP_W    = 16,
    parameter logic [STEP_W-1:0] FTW_STEP  = STEP_W'(1790),
    parameter int unsigned       OUT_W     = 10,
    parameter logic [10:0]       MAX_ADDR  = 11'd1800,
    parameter bit                SYNC_WRAP = 1'b0
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    input  logic [10:0]      Address,
    input  logic             FreqChng,
    output logic [OUT_W-1:0] PhaseOut,
    output logic [ACC_W-1:0] Ftw,
    output logic             Busy,
    output logic             FtwUpd,
    output logic             WrapPulse
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        WAIT_WRAP
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] product;
    logic [ACC_W-1:0] mcand;
    logic [10:0]      operand;
    logic [10:0]      pend_val;
    logic [10:0]      addr_clamp;
    logic [10:0]      load_val;
    logic [3:0]       bit_cnt;
    logic             pend;
    logic             commit;
    logic             load;
    logic [ACC_W:0]   acc_sum;
    logic             carry;

    assign addr_clamp = (Address > MAX_ADDR) ? MAX_ADDR : Address;
    assign acc_sum    = {1'b0, acc} + {1'b0, Ftw};
    assign carry      = acc_sum[ACC_W];

    // Next-state logic: decides when a product is committed and when a new
    // conversion (fresh strobe or pending request) is loaded.
    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        load     = 1'b0;
        load_val = addr_clamp;
        case (state)
            IDLE: begin
                if (FreqChng) begin
                    state_nx = MUL;
                    load     = 1'b1;
                end
            end
            MUL: begin
                if (bit_cnt == 4'd11) begin
                    if (!SYNC_WRAP || (Ftw == '0)) begin
                        commit = 1'b1;
                    end else begin
                        state_nx = WAIT_WRAP;
                    end
                end
            end
            WAIT_WRAP: begin
                if (carry) begin
                    commit = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A strobe landing on the commit cycle wins over an older pending value.
        if (commit) begin
            if (FreqChng || pend) begin
                state_nx = MUL;
                load     = 1'b1;
                load_val = FreqChng ? addr_clamp : pend_val;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Shift-add multiplier: one operand bit per cycle, LSB first.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            operand <= '0;
            product <= '0;
            mcand   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            operand <= load_val;
            product <= '0;
            mcand   <= ACC_W'(FTW_STEP);
            bit_cnt <= '0;
        end else if ((state == MUL) && (bit_cnt != 4'd11)) begin
            if (operand[0]) begin
                product <= product + mcand;
            end
            operand <= operand >> 1;
            mcand   <= mcand << 1;
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Pending request register: last strobe while busy wins; consumed on reload.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            pend     <= 1'b0;
            pend_val <= '0;
        end else if (commit && load) begin
            pend <= 1'b0;
        end else if (FreqChng && (state != IDLE)) begin
            pend     <= 1'b1;
            pend_val <= addr_clamp;
        end
    end

    // Tuning word commit and status outputs; Busy follows the state one edge
    // later so it spans the edge after the strobe through the commit edge.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            Ftw    <= '0;
            FtwUpd <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            if (commit) begin
                Ftw <= product;
            end
            FtwUpd <= commit;
            Busy   <= (state != IDLE);
        end
    end

    // Phase accumulator, carry pulse and registered ROM address.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            acc       <= '0;
            WrapPulse <= 1'b0;
            PhaseOut  <= '0;
        end else begin
            acc       <= acc_sum[ACC_W-1:0];
            WrapPulse <= carry;
            PhaseOut  <= acc[ACC_W-1 -: OUT_W];
        end
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Testbench for dds_phase_gen: table vectors, directed overlap/sync/reset
// sequences and randomized strobes checked against a timeline model.
module tb_dds_phase_gen;

    localparam int unsigned STEP = 1790;

    logic        clk = 1'b0;
    logic        rn  = 1'b0;
    logic [10:0] a0 = '0, a1 = '0, a2 = '0;
    logic        f0 = 1'b0, f1 = 1'b0, f2 = 1'b0;
    logic [9:0]  p0, p1, p2;
    logic [31:0] w0, w1, w2;
    logic        b0, b1, b2, u0, u1, u2, r0, r1, r2;

    always #5 clk = ~clk;

    dds_phase_gen dut0 (
        .Fg_CLK(clk), .RESETn(rn), .Address(a0), .FreqChng(f0),
        .PhaseOut(p0), .Ftw(w0), .Busy(b0), .FtwUpd(u0), .WrapPulse(r0)
    );

    dds_phase_gen #(.STEP_W(32), .FTW_STEP(32'h8000_0000)) dut1 (
        .Fg_CLK(clk), .RESETn(rn), .Address(a1), .FreqChng(f1),
        .PhaseOut(p1), .Ftw(w1), .Busy(b1), .FtwUpd(u1), .WrapPulse(r1)
    );

    dds_phase_gen #(.SYNC_WRAP(1'b1)) dut2 (
        .Fg_CLK(clk), .RESETn(rn), .Address(a2), .FreqChng(f2),
        .PhaseOut(p2), .Ftw(w2), .Busy(b2), .FtwUpd(u2), .WrapPulse(r2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] ftw_of(input int unsigned a);
        int unsigned c;
        c = (a > 1800) ? 1800 : a;
        return c * STEP;
    endfunction

    // dut0 timeline model: conversions are intervals [start, start+12];
    // strobes inside an interval become the (last-wins) pending request.
    bit                mon_en = 1'b0;
    int unsigned       upd_cnt0 = 0;
    longint unsigned   e = 0;
    longint unsigned   c_start = 0, c_end = 0;
    logic              s_f, s_r;
    logic [10:0]       s_a;
    logic [31:0]       m_acc = '0, m_ftw = '0, c_val = '0, p_val = '0;
    logic [9:0]        m_ph = '0;
    logic              m_wrap = 1'b0, m_upd = 1'b0, m_busy = 1'b0;
    bit                act = 1'b0, pend = 1'b0;

    always begin
        @(posedge clk);
        s_f = f0;
        s_a = a0;
        s_r = rn;
        e++;
        #1;
        if (mon_en) begin
            if (!s_r) begin
                m_acc = '0; m_ftw = '0; m_ph = '0; m_wrap = 1'b0;
                m_upd = 1'b0; m_busy = 1'b0; act = 1'b0; pend = 1'b0;
            end else begin
                m_busy = act && (e > c_start) && (e <= c_end);
                m_ph   = m_acc[31:22];
                {m_wrap, m_acc} = {1'b0, m_acc} + {1'b0, m_ftw};
                m_upd  = 1'b0;
                if (act && (e == c_end)) begin
                    m_ftw = c_val;
                    m_upd = 1'b1;
                    if (s_f) begin
                        c_val = ftw_of(s_a); c_start = e; c_end = e + 12; pend = 1'b0;
                    end else if (pend) begin
                        c_val = p_val; c_start = e; c_end = e + 12; pend = 1'b0;
                    end else begin
                        act = 1'b0;
                    end
                end else if (s_f) begin
                    if (act) begin
                        pend = 1'b1; p_val = ftw_of(s_a);
                    end else begin
                        act = 1'b1; c_start = e; c_end = e + 12; c_val = ftw_of(s_a);
                    end
                end
            end
            check("d0_ftw", w0, m_ftw);
            check("d0_phase", p0, m_ph);
            check("d0_wrap", r0, m_wrap);
            check("d0_upd", u0, m_upd);
            check("d0_busy", b0, m_busy);
            if (u0) upd_cnt0++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe0(input int unsigned addr);
        @(negedge clk);
        a0 = 11'(addr);
        f0 = 1'b1;
        @(negedge clk);
        f0 = 1'b0;
    endtask

    task automatic wait_upd(input int sel, input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #2;
            if ((sel == 0 && u0) || (sel == 1 && u1) || (sel == 2 && u2)) begin
                lat = k;
                return;
            end
        end
    endtask

    typedef struct {
        int unsigned addr;
        logic [31:0] ftw;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int unsigned c;
        logic [31:0] m2_acc, m2_ftw;
        logic [9:0]  ph;
        logic        cy, eu, eb;
        bit          done2;
        int          fin_j;

        vt[0] = '{1, 32'd1790};
        vt[1] = '{1800, 32'd3222000};
        vt[2] = '{2047, 32'd3222000};
        vt[3] = '{0, 32'd0};
        vt[4] = '{5, 32'd8950};
        vt[5] = '{1023, 32'd1831170};
        vt[6] = '{1024, 32'd1832960};
        vt[7] = '{1801, 32'd3222000};

        rn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ftw0", w0, 0);
        check("rst_phase0", p0, 0);
        check("rst_busy0", b0, 0);
        check("rst_upd0", u0, 0);
        check("rst_wrap0", r0, 0);
        check("rst_ftw1", w1, 0);
        check("rst_ftw2", w2, 0);
        rn = 1'b1;
        mon_en = 1'b1;

        // Half-scale tuning word: accumulator toggles between 0 and 2^31.
        @(negedge clk); a1 = 11'd1; f1 = 1'b1;
        @(negedge clk); f1 = 1'b0;
        wait_upd(1, 20, lat);
        check("d1_latency", lat, 12);
        check("d1_ftw", w1, 32'h8000_0000);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #2;
            check("d1_wrap", r1, (j % 2 == 0));
            check("d1_phase", p1, (j % 2 == 0) ? 10'h200 : 10'h000);
        end

        // Synchronous commit: old Ftw=0 commits without waiting.
        @(negedge clk); a2 = 11'd1800; f2 = 1'b1;
        @(negedge clk); f2 = 1'b0;
        wait_upd(2, 20, lat);
        check("d2_latency_first", lat, 12);
        check("d2_ftw_first", w2, 32'd3222000);
        // Then a second setting must wait for the next carry of the old word.
        m2_acc = '0;
        m2_ftw = 32'd3222000;
        done2  = 1'b0;
        fin_j  = 0;
        for (int j = 1; j <= 4000; j++) begin
            @(negedge clk);
            a2 = 11'd1000;
            f2 = (j == 3);
            @(posedge clk);
            ph = m2_acc[31:22];
            {cy, m2_acc} = {1'b0, m2_acc} + {1'b0, m2_ftw};
            eb = (j > 3) && !done2;
            eu = 1'b0;
            if (!done2 && (j >= 16) && cy) begin
                eu = 1'b1;
                m2_ftw = ftw_of(1000);
                done2 = 1'b1;
                fin_j = j;
            end
            #2;
            check("d2_wrap", r2, cy);
            check("d2_upd", u2, eu);
            check("d2_phase", p2, ph);
            check("d2_ftw", w2, m2_ftw);
            check("d2_busy", b2, eb);
            if (done2 && (j >= fin_j + 4)) break;
        end
        check("d2_committed", done2, 1);

        // Table vectors on the immediate-commit instance.
        for (int i = 0; i < 8; i++) begin
            strobe0(vt[i].addr);
            wait_upd(0, 20, lat);
            check("tbl_latency", lat, 12);
            check("tbl_ftw", w0, vt[i].ftw);
            idle(6);
        end

        // Strobes during MUL: first commits, last of the rest wins.
        c = upd_cnt0;
        strobe0(5); idle(1); strobe0(6); idle(1); strobe0(7);
        idle(40);
        check("ovl_upd_count", upd_cnt0 - c, 2);
        check("ovl_ftw", w0, 32'd12530);

        // Strobe exactly on the commit edge.
        c = upd_cnt0;
        strobe0(3); idle(10); strobe0(11);
        idle(40);
        check("cmt_upd_count", upd_cnt0 - c, 2);
        check("cmt_ftw", w0, 32'd19690);

        // Random strobes, including while busy and out-of-range addresses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            f0 = ($urandom_range(0, 11) == 0);
            a0 = 11'($urandom_range(0, 2047));
        end
        @(negedge clk); f0 = 1'b0;
        idle(30);

        // Reset in the middle of a conversion discards it.
        c = upd_cnt0;
        strobe0(9);
        idle(4);
        @(posedge clk);
        #3 rn = 1'b0;
        #1;
        check("mid_rst_ftw", w0, 0);
        check("mid_rst_phase", p0, 0);
        check("mid_rst_busy", b0, 0);
        check("mid_rst_upd", u0, 0);
        check("mid_rst_wrap", r0, 0);
        repeat (2) @(negedge clk);
        rn = 1'b1;
        idle(20);
        check("post_rst_upd_count", upd_cnt0 - c, 0);
        check("post_rst_ftw", w0, 0);
        check("post_rst_busy", b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
